// File: rtl/frogger_pkg.sv
// Shared frogger types and screen geometry, used by the frog, car and sprite blocks.
package frogger_pkg;

    typedef enum logic [1:0] {ALIVE, HOP, DYING, GAME_OVER} frog_state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} hop_dir_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FROG_SIDE = 40;
    localparam int POS_W     = 11;

endpackage

// File: rtl/frog_ctrl_if.sv
// Frog <-> keypad/car-layer bundle; master is the frog controller, slave is its environment.
interface frog_ctrl_if
    import frogger_pkg::*;
#(
    parameter int NUM_CARS = 8
);
    logic                Key_Up;
    logic                Key_Down;
    logic                Key_Left;
    logic                Key_Right;
    logic [NUM_CARS-1:0] Car_Collision;
    logic [POS_W-1:0]    Frog_X;
    logic [POS_W-1:0]    Frog_Y;
    logic [1:0]          Lives;
    logic [7:0]          Score;
    logic                Dying;
    logic                Game_Over;
    logic                Invuln;

    modport master (
        input  Key_Up, Key_Down, Key_Left, Key_Right, Car_Collision,
        output Frog_X, Frog_Y, Lives, Score, Dying, Game_Over, Invuln
    );

    modport slave (
        output Key_Up, Key_Down, Key_Left, Key_Right, Car_Collision,
        input  Frog_X, Frog_Y, Lives, Score, Dying, Game_Over, Invuln
    );
endinterface

// File: rtl/frog_ctrl_key_edge.sv
// Registered rising-edge detector for one keypad line.
module key_edge (
    input  logic frame_clk,
    input  logic Reset,
    input  logic key,
    output logic rise
);
    logic cur;
    logic prev;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= key;
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;
endmodule

// File: rtl/frog_ctrl.sv
// Frog player controller: hops, death/respawn, lives, home scoring, game over.
// Optional post-respawn grace period is enabled by defining FROG_INVULN_EN.
module frog_ctrl
    import frogger_pkg::*;
#(
    parameter int NUM_CARS      = 8,
    parameter int START_X       = 300,
    parameter int START_Y       = 440,
    parameter int HOP_STEP      = 10,
    parameter int HOP_FRAMES    = 4,
    parameter int DEATH_FRAMES  = 30,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic         frame_clk,
    input  logic         Reset,
    frog_ctrl_if.master  bus
);
    // state | meaning
    // ALIVE     | idle at a cell, accepting hop requests
    // HOP       | moving HOP_STEP px per frame toward the target cell
    // DYING     | death animation, position frozen
    // GAME_OVER | terminal until Reset

    localparam int HCW = $clog2(HOP_FRAMES + 1);
    localparam int DCW = $clog2(DEATH_FRAMES + 1);
    localparam logic [POS_W-1:0] STEP  = POS_W'(HOP_STEP);
    localparam logic [POS_W-1:0] SIDE  = POS_W'(FROG_SIDE);
    localparam logic [POS_W-1:0] MAX_X = POS_W'(SCREEN_W - FROG_SIDE);
    localparam logic [POS_W-1:0] MAX_Y = POS_W'(SCREEN_H - FROG_SIDE);
    localparam logic [POS_W-1:0] X0    = POS_W'(START_X);
    localparam logic [POS_W-1:0] Y0    = POS_W'(START_Y);

    logic rq_up, rq_down, rq_left, rq_right;

    key_edge u_edge_up    (.frame_clk(frame_clk), .Reset(Reset), .key(bus.Key_Up),    .rise(rq_up));
    key_edge u_edge_down  (.frame_clk(frame_clk), .Reset(Reset), .key(bus.Key_Down),  .rise(rq_down));
    key_edge u_edge_left  (.frame_clk(frame_clk), .Reset(Reset), .key(bus.Key_Left),  .rise(rq_left));
    key_edge u_edge_right (.frame_clk(frame_clk), .Reset(Reset), .key(bus.Key_Right), .rise(rq_right));

    frog_state_t      state;
    hop_dir_t         dir;
    hop_dir_t         req_dir;
    logic [HCW-1:0]   hop_cnt;
    logic [DCW-1:0]   death_cnt;
    logic [POS_W-1:0] pos_x, pos_y, nxt_x, nxt_y;
    logic [1:0]       lives;
    logic [7:0]       score;
    logic             dying, game_over;
    logic             req_val, req_ok, hit, invuln;

    // Up/left bounds are tested as origin >= SIDE so the subtraction never wraps.
    always_comb begin
        req_val = rq_up | rq_down | rq_left | rq_right;
        req_dir = RIGHT;
        if (rq_up)        req_dir = UP;
        else if (rq_down) req_dir = DOWN;
        else if (rq_left) req_dir = LEFT;
        req_ok = 1'b0;
        case (req_dir)
            UP:      req_ok = pos_y >= SIDE;
            DOWN:    req_ok = pos_y <= MAX_Y - SIDE;
            LEFT:    req_ok = pos_x >= SIDE;
            default: req_ok = pos_x <= MAX_X - SIDE;
        endcase
    end

    always_comb begin
        nxt_x = pos_x;
        nxt_y = pos_y;
        case (dir)
            UP:      nxt_y = pos_y - STEP;
            DOWN:    nxt_y = pos_y + STEP;
            LEFT:    nxt_x = pos_x - STEP;
            default: nxt_x = pos_x + STEP;
        endcase
    end

`ifdef FROG_INVULN_EN
    localparam int ICW = $clog2(INVULN_FRAMES + 1);
    logic [ICW-1:0] invuln_cnt;
    assign invuln = invuln_cnt != '0;
`else
    // Grace period compiled out; the comparison is constant false for any legal INVULN_FRAMES.
    assign invuln = (INVULN_FRAMES < 0);
`endif

    assign hit = (|bus.Car_Collision[NUM_CARS-1:0]) && !invuln;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= ALIVE;
            dir       <= UP;
            hop_cnt   <= '0;
            death_cnt <= '0;
            pos_x     <= X0;
            pos_y     <= Y0;
            lives     <= 2'(LIVES_INIT);
            score     <= '0;
            dying     <= 1'b0;
            game_over <= 1'b0;
`ifdef FROG_INVULN_EN
            invuln_cnt <= '0;
`endif
        end else begin
`ifdef FROG_INVULN_EN
            if (invuln_cnt != '0) invuln_cnt <= invuln_cnt - 1'b1;
`endif
            case (state)
                ALIVE, HOP: begin
                    if (hit) begin
                        state     <= DYING;
                        dying     <= 1'b1;
                        death_cnt <= DCW'(DEATH_FRAMES - 1);
                        lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    end else if (state == HOP) begin
                        pos_x <= nxt_x;
                        pos_y <= nxt_y;
                        if (hop_cnt == '0) begin
                            state <= ALIVE;
                            // Reaching the home row scores and teleports on the same edge.
                            if (nxt_y == '0) begin
                                pos_x <= X0;
                                pos_y <= Y0;
                                if (score != 8'hFF) score <= score + 8'd1;
                            end
                        end else begin
                            hop_cnt <= hop_cnt - 1'b1;
                        end
                    end else if (req_val && req_ok) begin
                        state   <= HOP;
                        dir     <= req_dir;
                        hop_cnt <= HCW'(HOP_FRAMES - 1);
                    end
                end
                DYING: begin
                    if (death_cnt == '0) begin
                        dying <= 1'b0;
                        if (lives == 2'd0) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= ALIVE;
                            pos_x <= X0;
                            pos_y <= Y0;
`ifdef FROG_INVULN_EN
                            invuln_cnt <= ICW'(INVULN_FRAMES);
`endif
                        end
                    end else begin
                        death_cnt <= death_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Frog_X    = pos_x;
    assign bus.Frog_Y    = pos_y;
    assign bus.Lives     = lives;
    assign bus.Score     = score;
    assign bus.Dying     = dying;
    assign bus.Game_Over = game_over;
    assign bus.Invuln    = invuln;
endmodule

// File: tb/tb_frog_ctrl.sv
// Bench for frog_ctrl: frame-level behavioural model compared every cycle, plus directed literal checks.
module tb_frog_ctrl;
    localparam int START_X = 300;
    localparam int START_Y = 440;
    localparam int DEATH   = 30;
`ifdef FROG_INVULN_EN
    localparam int GRACE = 60;
`else
    localparam int GRACE = 0;
`endif

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;
    bit   check_en  = 1'b0;

    frog_ctrl_if #(.NUM_CARS(8)) bus ();

    frog_ctrl #(.NUM_CARS(8)) u_dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 frame_clk = ~frame_clk;

    // Model: position, lives, score, plus frames left in the current hop / death / grace period.
    int       mx, my, mlives, mscore, hop_left, hdx, hdy, dying_left, inv_left;
    bit       over;
    bit [3:0] kc, kp;

    function automatic void model_reset();
        mx = START_X; my = START_Y; mlives = 3; mscore = 0;
        hop_left = 0; hdx = 0; hdy = 0; dying_left = 0; inv_left = 0;
        over = 1'b0; kc = '0; kp = '0;
    endfunction

    function automatic void model_step();
        bit [3:0] kn;
        bit [3:0] req;
        bit       coll;
        int       tx, ty, dx, dy;
        kn   = {bus.Key_Right, bus.Key_Left, bus.Key_Down, bus.Key_Up};
        req  = kc & ~kp;
        kp   = kc;
        kc   = kn;
        coll = (bus.Car_Collision != 0) && (inv_left == 0);
        if (over) return;
        if (inv_left > 0) inv_left--;
        if (dying_left > 0) begin
            dying_left--;
            if (dying_left == 0) begin
                if (mlives == 0) over = 1'b1;
                else begin
                    mx = START_X; my = START_Y; inv_left = GRACE;
                end
            end
        end else if (coll) begin
            dying_left = DEATH;
            if (mlives > 0) mlives--;
            hop_left = 0;
        end else if (hop_left > 0) begin
            mx += hdx; my += hdy; hop_left--;
            if (hop_left == 0 && my == 0) begin
                if (mscore < 255) mscore++;
                mx = START_X; my = START_Y;
            end
        end else if (req != 0) begin
            dx = 0; dy = 0;
            if (req[0])      dy = -1;
            else if (req[1]) dy = 1;
            else if (req[2]) dx = -1;
            else             dx = 1;
            tx = mx + 40 * dx;
            ty = my + 40 * dy;
            if (tx >= 0 && tx <= 600 && ty >= 0 && ty <= 440) begin
                hop_left = 4; hdx = 10 * dx; hdy = 10 * dy;
            end
        end
    endfunction

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) model_reset();
        else       model_step();
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge frame_clk) begin
        if (check_en && !Reset) begin
            chk("Frog_X",    int'(bus.Frog_X),    mx);
            chk("Frog_Y",    int'(bus.Frog_Y),    my);
            chk("Lives",     int'(bus.Lives),     mlives);
            chk("Score",     int'(bus.Score),     mscore);
            chk("Dying",     int'(bus.Dying),     int'(dying_left > 0));
            chk("Game_Over", int'(bus.Game_Over), int'(over));
            chk("Invuln",    int'(bus.Invuln),    int'(inv_left > 0));
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge frame_clk);
            #2;
        end
    endtask

    task automatic keys(bit [3:0] m);
        bus.Key_Up    = m[0];
        bus.Key_Down  = m[1];
        bus.Key_Left  = m[2];
        bus.Key_Right = m[3];
    endtask

    task automatic press(bit [3:0] m);
        keys(m);
        tick(1);
        keys(4'b0000);
        tick(6);
    endtask

    task automatic collide();
        bus.Car_Collision = 8'h20;
        tick(1);
        bus.Car_Collision = 8'h00;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        tick(1);
    endtask

    initial begin
        keys(4'b0000);
        bus.Car_Collision = 8'h00;
        repeat (2) @(posedge frame_clk);
        #2;
        Reset    = 1'b0;
        check_en = 1'b1;

        chk("reset_x", int'(bus.Frog_X), 300);
        chk("reset_y", int'(bus.Frog_Y), 440);
        chk("reset_lives", int'(bus.Lives), 3);
        chk("reset_score", int'(bus.Score), 0);
        chk("reset_go", int'(bus.Game_Over), 0);

        // Single Up pulse: registered edge, one entry frame, then 4 step frames.
        keys(4'b0001);
        tick(1);
        keys(4'b0000);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("hop_up_y", int'(bus.Frog_Y), 430 - 10 * i);
        end
        chk("hop_up_x", int'(bus.Frog_X), 300);

        for (int i = 0; i < 7; i++) press(4'b0100);
        chk("left_x", int'(bus.Frog_X), 20);
        press(4'b0100);
        chk("left_blocked_x", int'(bus.Frog_X), 20);
        press(4'b1001);
        chk("up_prio_x", int'(bus.Frog_X), 20);
        chk("up_prio_y", int'(bus.Frog_Y), 360);

        keys(4'b0010);
        tick(20);
        keys(4'b0000);
        tick(2);
        chk("held_down_y", int'(bus.Frog_Y), 400);

        keys(4'b0001);
        tick(1);
        keys(4'b0000);
        tick(2);
        keys(4'b1000);
        tick(1);
        keys(4'b0000);
        tick(8);
        chk("drop_x", int'(bus.Frog_X), 20);
        chk("drop_y", int'(bus.Frog_Y), 360);

        // Collision two step frames into a hop.
        keys(4'b0001);
        tick(1);
        keys(4'b0000);
        tick(3);
        collide();
        chk("die_dying", int'(bus.Dying), 1);
        chk("die_lives", int'(bus.Lives), 2);
        chk("die_frozen_y", int'(bus.Frog_Y), 340);
        tick(29);
        chk("die_still", int'(bus.Dying), 1);
        tick(1);
        chk("respawn_dying", int'(bus.Dying), 0);
        chk("respawn_x", int'(bus.Frog_X), 300);
        chk("respawn_y", int'(bus.Frog_Y), 440);

`ifdef FROG_INVULN_EN
        collide();
        chk("grace_invuln", int'(bus.Invuln), 1);
        chk("grace_dying", int'(bus.Dying), 0);
`endif
        tick(62);
        collide();
        tick(30);
        tick(62);
        collide();
        chk("last_lives", int'(bus.Lives), 0);
        tick(30);
        chk("game_over", int'(bus.Game_Over), 1);
        for (int i = 0; i < 40; i++) begin
            keys(4'($urandom_range(15)));
            bus.Car_Collision = 8'($urandom_range(255));
            tick(1);
        end
        keys(4'b0000);
        bus.Car_Collision = 8'h00;
        chk("over_hold_y", int'(bus.Frog_Y), 440);
        chk("over_hold_lives", int'(bus.Lives), 0);

        pulse_reset();
        chk("rst_lives", int'(bus.Lives), 3);
        chk("rst_go", int'(bus.Game_Over), 0);
        for (int i = 0; i < 10; i++) press(4'b0001);
        chk("near_home_y", int'(bus.Frog_Y), 40);
        press(4'b0001);
        chk("home_score", int'(bus.Score), 1);
        chk("home_y", int'(bus.Frog_Y), 440);
        chk("home_x", int'(bus.Frog_X), 300);

        // Randomized frames, including async resets that can land mid-hop or mid-death.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) keys(4'($urandom_range(15)));
            bus.Car_Collision = ($urandom_range(59) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
            if ($urandom_range(499) == 0) pulse_reset();
            else                          tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
